branch_fetch_ctrl: RTL and testbench
====================================

Name: branch_fetch_ctrl

Overview:
Fetch-stage PC generator that sits downstream of the 2-bit-style branch predictor. It consumes the predictor's taken hint and predicted target to steer the fetch PC, and records every predicted branch in an in-order prediction queue. When the execute stage resolves a branch, the block checks the oldest queued prediction; on a mismatch it redirects the PC and issues a one-cycle pipeline flush. It also keeps branch and mispredict statistics.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset
QDEPTH, 4, prediction queue entries (power of 2, ≥2)
QAW, 2, log2(QDEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  downstream fetch stall; PC and queue push frozen
branch_f  in  1  instruction at current pc is a branch (predecode)
pred_taken  in  1  predictor taken hint (next_branch_h)
pred_target  in  32  predictor target (pc_branch_predict)
res_valid  in  1  execute stage resolves oldest branch this cycle
res_taken  in  1  actual branch outcome
res_target  in  32  actual branch target
pc  out  32  current fetch address
fetch_hold  out  1  branch at pc blocked by full queue
flush  out  1  registered one-cycle flush of younger instructions
redirect_pc  out  32  corrected PC accompanying flush
q_count  out  QAW+1  queued unresolved predictions
protocol_err  out  1  sticky: res_valid with empty queue
branch_cnt  out  32  resolved branches
mispred_cnt  out  32  mispredicted branches

Behaviour:
- Reset (synchronous, rst=1 at posedge): pc=RESET_PC, queue empty, q_count=0, flush=0, redirect_pc=0, fetch_hold=0, protocol_err=0, both counters=0.
- Queue entry: {bpc[31:0], ptaken, ptarget[31:0]}. Circular buffer, rd/wr pointers QAW bits wrap modulo QDEPTH, count QAW+1 bits.
- fetch_hold (combinational) = branch_f & full & !pop, where pop = res_valid & !empty. Pop frees a slot the same cycle, so push is allowed when full with pop.
- Advance condition adv = !stall & !fetch_hold & !mispredict.
- On adv: next pc = (branch_f & pred_taken) ? pred_target : pc+4 (32-bit, wraps at 2^32). If branch_f, push {pc, pred_taken, pred_target}.
- On !adv with no mispredict: pc holds; no push.
- Resolution (pop): head entry compared. mispredict = pop & ((res_taken != ptaken) | (res_taken & ptaken & res_target != ptarget)). Correct PC = res_taken ? res_target : bpc+4.
- Mispredict has priority over stall, fetch_hold and any same-cycle push: next cycle pc=correct PC, queue cleared (pointers and count =0, same-cycle push discarded), flush=1, redirect_pc=correct PC. flush is high for exactly one cycle per mispredict. Back-to-back mispredicts are impossible because the queue is cleared.
- Correct prediction: head popped, no flush, pc follows the adv rule.
- branch_cnt += 1 on every pop; mispred_cnt += 1 on every mispredict. Both saturate at 32'hFFFF_FFFF.
- res_valid while empty: ignored (no pop, no flush), protocol_err set and held until rst.
- Simultaneous push+pop without mispredict: count unchanged, pointers both advance.
- rst asserted mid-operation overrides everything in that cycle.

Test Plan:
- Reset then 3 cycles, no branches, stall=0 -> pc sequence 8000_0000, 8000_0004, 8000_0008, 8000_000C; flush=0; q_count=0.
- At pc=8000_0008: branch_f=1, pred_taken=1, pred_target=8000_0100 -> next pc=8000_0100, q_count=1. Then res_valid=1, res_taken=1, res_target=8000_0100 -> no flush, q_count=0, branch_cnt=1.
- Same push with pred_taken=0, then resolve res_taken=1, res_target=8000_0200 -> next cycle flush=1, pc=redirect_pc=8000_0200, q_count=0, mispred_cnt=1; flush=0 the following cycle.
- Predicted taken to 8000_0100 resolved not-taken, branch pc 8000_0008 -> pc=8000_000C, flush=1. Taken with target mismatch (8000_0104) -> pc=8000_0104, flush=1.
- Push 4 branches (QDEPTH=4) with no resolve, then branch_f=1 -> fetch_hold=1, pc frozen. Same state with res_valid=1 (correct) -> push accepted, q_count stays 4.
- res_valid=1 on empty queue -> protocol_err=1 (sticky), no flush, pc unaffected. stall=1 with mispredicting resolve -> redirect still taken next cycle.

Source files
------------

// File: rtl/branch_fetch_ctrl.sv
// Fetch-stage PC generator: steers the PC from predictor hints, queues every
// predicted branch in order, and redirects/flushes when execute disagrees.
module branch_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          QDEPTH   = 4,
  parameter int          QAW      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           branch_f,
  input  logic           pred_taken,
  input  logic [31:0]    pred_target,
  input  logic           res_valid,
  input  logic           res_taken,
  input  logic [31:0]    res_target,
  output logic [31:0]    pc,
  output logic           fetch_hold,
  output logic           flush,
  output logic [31:0]    redirect_pc,
  output logic [QAW:0]   q_count,
  output logic           protocol_err,
  output logic [31:0]    branch_cnt,
  output logic [31:0]    mispred_cnt
);

  localparam logic [QAW:0] DEPTH_C = (QAW+1)'(QDEPTH);

  logic [31:0]    pc_q, pc_d;
  logic [QAW-1:0] rd_ptr_q, wr_ptr_q;
  logic [QAW:0]   count_q, count_d;
  logic           flush_q;
  logic [31:0]    redirect_q;
  logic           perr_q;
  logic [31:0]    branch_cnt_q, mispred_cnt_q;

  logic [31:0]    bpc_mem     [QDEPTH];
  logic           ptaken_mem  [QDEPTH];
  logic [31:0]    ptarget_mem [QDEPTH];

  logic        empty, full, pop, push, adv, mispredict;
  logic [31:0] head_bpc, head_ptarget, correct_pc;
  logic        head_ptaken;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign pop          = res_valid & ~empty;
  assign head_bpc     = bpc_mem[rd_ptr_q];
  assign head_ptaken  = ptaken_mem[rd_ptr_q];
  assign head_ptarget = ptarget_mem[rd_ptr_q];

  // A pop frees the head slot this cycle, so a full queue can still accept a push.
  assign fetch_hold = branch_f & full & ~pop;
  assign mispredict = pop & ((res_taken != head_ptaken) |
                             (res_taken & head_ptaken & (res_target != head_ptarget)));
  assign correct_pc = res_taken ? res_target : head_bpc + 32'd4;
  assign adv        = ~stall & ~fetch_hold & ~mispredict;
  assign push       = adv & branch_f;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pc_d    = pc_q;
    count_d = count_q;
    if (adv) pc_d = (branch_f & pred_taken) ? pred_target : pc_q + 32'd4;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      perr_q        <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (res_valid & empty) perr_q <= 1'b1;
      if (pop && branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;

      if (mispredict) begin
        pc_q       <= correct_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        flush_q    <= 1'b1;
        redirect_q <= correct_pc;
        if (mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end else begin
        pc_q    <= pc_d;
        count_q <= count_d;
        flush_q <= 1'b0;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: queue storage is not reset; the count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      bpc_mem[wr_ptr_q]     <= pc_q;
      ptaken_mem[wr_ptr_q]  <= pred_taken;
      ptarget_mem[wr_ptr_q] <= pred_target;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_q;
  assign redirect_pc  = redirect_q;
  assign q_count      = count_q;
  assign protocol_err = perr_q;
  assign branch_cnt   = branch_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Self-checking bench for branch_fetch_ctrl: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_branch_fetch_ctrl;

  localparam int QDEPTH = 4;
  localparam int QAW    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stall = 1'b0, branch_f = 1'b0, pred_taken = 1'b0;
  logic [31:0]    pred_target = '0;
  logic           res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0]    res_target = '0;
  logic [31:0]    pc, redirect_pc, branch_cnt, mispred_cnt;
  logic           fetch_hold, flush, protocol_err;
  logic [QAW:0]   q_count;

  int checks = 0;
  int failures = 0;

  branch_fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .QAW(QAW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_f(branch_f),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .pc(pc), .fetch_hold(fetch_hold), .flush(flush), .redirect_pc(redirect_pc),
    .q_count(q_count), .protocol_err(protocol_err),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bpc;
    logic        pt;
    logic [31:0] ptgt;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc, m_redir, m_bcnt, m_mcnt;
  logic        m_flush, m_perr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", 64'(pc), 64'(m_pc));
    check("q_count", 64'(q_count), 64'(m_q.size()));
    check("flush", 64'(flush), 64'(m_flush));
    check("redirect_pc", 64'(redirect_pc), 64'(m_redir));
    check("protocol_err", 64'(protocol_err), 64'(m_perr));
    check("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
    check("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; branch_f = 1'b0; pred_taken = 1'b0;
    pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q.delete();
    m_pc = RESET_PC; m_redir = '0; m_bcnt = '0; m_mcnt = '0;
    m_flush = 1'b0; m_perr = 1'b0;
    check_all();
    check("rst_fetch_hold", 64'(fetch_hold), 64'(0));
  endtask

  // One cycle: drive, check the combinational hold, advance the model, clock, compare.
  task automatic step(input logic st, input logic bf, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    bit          pop, mis, hold;
    logic [31:0] corr;
    ent_t        h;
    @(negedge clk);
    stall = st; branch_f = bf; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    pop  = rv && m_q.size() != 0;
    hold = bf && m_q.size() == QDEPTH && !pop;
    mis  = 1'b0;
    corr = '0;
    #1;
    check("fetch_hold", 64'(fetch_hold), 64'(hold));
    if (rv && m_q.size() == 0) m_perr = 1'b1;
    if (pop) begin
      h = m_q.pop_front();
      mis  = (rt != h.pt) || (rt && h.ptgt != rtg);
      corr = rt ? rtg : h.bpc + 32'd4;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    end
    if (mis) begin
      m_q.delete();
      m_pc = corr; m_redir = corr; m_flush = 1'b1;
      if (m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    end else begin
      m_flush = 1'b0;
      if (!st && !hold) begin
        if (bf) m_q.push_back('{bpc: m_pc, pt: pt, ptgt: ptg});
        m_pc = (bf && pt) ? ptg : m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    // Sequential fetch after reset.
    do_reset();
    check("reset_pc", 64'(pc), 64'(32'h8000_0000));
    idle(); idle(); idle();
    check("seq_pc", 64'(pc), 64'(32'h8000_000C));

    // Correctly predicted taken branch.
    do_reset(); idle(); idle();
    step(0, 1, 1, 32'h8000_0100, 0, 0, '0);
    check("pt_pc", 64'(pc), 64'(32'h8000_0100));
    check("pt_qcount", 64'(q_count), 64'(1));
    step(0, 0, 0, '0, 1, 1, 32'h8000_0100);
    check("pt_noflush", 64'(flush), 64'(0));
    check("pt_bcnt", 64'(branch_cnt), 64'(1));

    // Predicted not-taken, actually taken.
    do_reset(); idle(); idle();
    step(0, 1, 0, 32'h8000_0100, 0, 0, '0);
    step(0, 0, 0, '0, 1, 1, 32'h8000_0200);
    check("mp_flush", 64'(flush), 64'(1));
    check("mp_pc", 64'(pc), 64'(32'h8000_0200));
    check("mp_redir", 64'(redirect_pc), 64'(32'h8000_0200));
    check("mp_mcnt", 64'(mispred_cnt), 64'(1));
    idle();
    check("mp_flush_drop", 64'(flush), 64'(0));

    // Predicted taken, actually not taken.
    do_reset(); idle(); idle();
    step(0, 1, 1, 32'h8000_0100, 0, 0, '0);
    step(0, 0, 0, '0, 1, 0, '0);
    check("nt_pc", 64'(pc), 64'(32'h8000_000C));
    check("nt_flush", 64'(flush), 64'(1));

    // Taken with wrong target.
    do_reset(); idle(); idle();
    step(0, 1, 1, 32'h8000_0100, 0, 0, '0);
    step(0, 0, 0, '0, 1, 1, 32'h8000_0104);
    check("tgt_pc", 64'(pc), 64'(32'h8000_0104));
    check("tgt_flush", 64'(flush), 64'(1));

    // Fill the queue, then hold, then push alongside a correct pop.
    do_reset();
    for (int i = 0; i < QDEPTH; i++) step(0, 1, 0, 32'h9000_0000, 0, 0, '0);
    check("full_qcount", 64'(q_count), 64'(4));
    step(0, 1, 0, 32'h9000_0000, 0, 0, '0);
    check("full_pc_frozen", 64'(pc), 64'(32'h8000_0010));
    #1;
    check("full_hold", 64'(fetch_hold), 64'(1));
    step(0, 1, 0, 32'h9000_0000, 1, 0, '0);
    check("full_pushpop_q", 64'(q_count), 64'(4));
    check("full_pushpop_pc", 64'(pc), 64'(32'h8000_0014));

    // Resolve on empty queue, then a mispredict under stall.
    do_reset();
    step(0, 0, 0, '0, 1, 1, 32'h1234_5678);
    check("perr_set", 64'(protocol_err), 64'(1));
    check("perr_noflush", 64'(flush), 64'(0));
    check("perr_pc", 64'(pc), 64'(32'h8000_0004));
    step(0, 1, 0, 32'h8000_0400, 0, 0, '0);
    step(1, 0, 0, '0, 1, 1, 32'h8000_0500);
    check("stall_mp_pc", 64'(pc), 64'(32'h8000_0500));
    check("stall_mp_flush", 64'(flush), 64'(1));
    check("perr_sticky", 64'(protocol_err), 64'(1));

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        st, bf, pt, rv, rt;
      logic [31:0] ptg, rtg;
      if ($urandom_range(0, 299) == 0) do_reset();
      st  = ($urandom_range(0, 5) == 0);
      bf  = ($urandom_range(0, 2) == 0);
      pt  = $urandom_range(0, 1);
      ptg = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      rv  = ($urandom_range(0, 3) == 0);
      rt  = $urandom_range(0, 1);
      rtg = $urandom & 32'hFFFF_FFFC;
      if (m_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt  = ($urandom_range(0, 4) == 0) ? ~m_q[0].pt : m_q[0].pt;
        rtg = m_q[0].ptgt;
      end
      step(st, bf, pt, ptg, rv, rt, rtg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
